// File: rtl/data_mem_lsu_if.sv
// Request/response bus between the MEM stage and the data memory load/store unit.
// A request transfers on a rising edge where req_valid && req_ready (and the block's clk_en);
// req_* must be held stable while req_valid is high and not yet accepted. rsp_valid is a
// one-enabled-cycle strobe; rsp_rdata/rsp_err are meaningful only while it is high.
interface data_mem_lsu_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_lsu.sv
// Data memory with an RV32I load/store front end: byte/half/word accesses, error checks
// at accept, and a configurable number of wait states before the response strobe.
module data_mem_lsu #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  data_mem_lsu_if.slave    bus,
  output logic [1:0]       dbg_state
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        ready, accept;
  logic        err_q, load_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [31:0] rd_word;
  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]   offset;
  logic [2:0]    f3;
  logic          misaligned, out_of_range, illegal, req_err;
  logic [AW-1:0] widx;
  logic [3:0]    be;
  logic [31:0]   wrep;

  assign accept = bus.req_valid && ready && clk_en;
  assign f3     = bus.req_funct3;
  assign offset = bus.req_addr - BASE_ADDR;
  assign widx   = offset[2 +: AW];

  // Size lives in funct3[1:0]; funct3[2] only selects zero extension for loads.
  assign misaligned   = ((f3[1:0] == 2'b01) && bus.req_addr[0]) ||
                        ((f3 == 3'b010) && (bus.req_addr[1:0] != 2'b00));
  assign out_of_range = (bus.req_addr < BASE_ADDR) || (offset >= SPAN);
  assign illegal      = bus.req_we ? (f3[2] || (f3[1:0] == 2'b11))
                                   : ((f3 == 3'b011) || (f3[2:1] == 2'b11));
  assign req_err      = misaligned || out_of_range || illegal;

  always_comb begin
    be   = 4'b1111;
    wrep = bus.req_wdata;
    case (f3[1:0])
      2'b00: begin
        be   = 4'b0001 << bus.req_addr[1:0];
        wrep = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        be   = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wrep = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Stores commit on the accept edge, so a following load always sees them.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (bus.req_we && !req_err) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[widx][8*i +: 8] <= wrep[8*i +: 8];
        end
      end
      if (!bus.req_we) rd_word <= mem[widx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      err_q  <= 1'b0;
      load_q <= 1'b0;
      f3_q   <= 3'b000;
      lane_q <= 2'b00;
    end else if (clk_en) begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        err_q  <= req_err;
        load_q <= !bus.req_we;
        f3_q   <= f3;
        lane_q <= bus.req_addr[1:0];
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ready    = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (bus.req_valid) begin
          if (WAIT_STATES > 0) begin
            state_nx = S_WAIT;
            cnt_nx   = CNT_INIT;
          end else begin
            state_nx = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_nx = S_RESP;
        else             cnt_nx   = cnt - 4'd1;
      end
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  logic [7:0]  sel_b;
  logic [15:0] sel_h;
  logic [31:0] ext;

  always_comb begin
    sel_b = rd_word[8*lane_q +: 8];
    sel_h = lane_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (f3_q)
      3'b000:  ext = {{24{sel_b[7]}}, sel_b};
      3'b100:  ext = {24'd0, sel_b};
      3'b001:  ext = {{16{sel_h[15]}}, sel_h};
      3'b101:  ext = {16'd0, sel_h};
      default: ext = rd_word;
    endcase
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_err   = (state == S_RESP) && err_q;
  assign bus.rsp_rdata = ((state == S_RESP) && load_q && !err_q) ? ext : 32'd0;
  assign dbg_state     = state;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: directed test-plan cases plus randomized traffic, all checked
// against a byte-array memory model through an expected-response queue.
module tb_data_mem_lsu;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int          WS    = 2;
  localparam int          SPAN  = DEPTH * 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_en;
  logic [1:0] dbg_state;

  data_mem_lsu_if bus();

  data_mem_lsu #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE),
    .WAIT_STATES(WS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .bus      (bus.slave),
    .dbg_state(dbg_state)
  );

  // clock / reset / counters
  always #5 clk = ~clk;

  int cyc = 0;
  int en_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clk_en && !rst) en_cnt <= en_cnt + 1;
  end

  logic rand_en = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rand_en) clk_en = ($urandom_range(0, 3) != 0);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: plain byte-addressed memory
  logic [7:0]  mm [SPAN];
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  int          exp_en_q[$];

  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic e, output logic [31:0] rd);
    logic [31:0] off;
    int sz;
    off = a - BASE;
    sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    e   = (a < BASE) || (a >= BASE + SPAN);
    if (sz > 1 && (a % sz) != 0) e = 1'b1;
    if (we) begin
      if (f3 > 3'd2) e = 1'b1;
    end else if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) begin
      e = 1'b1;
    end
    rd = 32'd0;
    if (!e) begin
      if (we) begin
        for (int i = 0; i < sz; i++) mm[off + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < sz; i++) rd[8*i +: 8] = mm[off + i];
        if (!f3[2] && sz < 4 && rd[8*sz-1])
          for (int i = sz; i < 4; i++) rd[8*i +: 8] = 8'hFF;
      end
    end
  endtask

  // driver: called at posedge+1; returns at posedge+1 just after the accept edge
  int acc_cyc;
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic e);
    int n;
    n = 0;
    rd = 32'd0;
    e  = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.req_ready && clk_en) && n < 50);
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
      bus.req_valid = 1'b0;
      return;
    end
    model(we, f3, a, wd, e, rd);
    exp_q.push_back(rd);
    exp_err_q.push_back(e);
    exp_en_q.push_back(en_cnt + 1 + WS);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  // scoreboard / compare process
  logic        flush = 1'b0;
  logic [31:0] c_rd;
  logic        c_e;
  int          c_en;
  int          last_rsp_cyc = 0;
  always @(negedge clk) begin
    if (!rst && !flush) begin
      if (bus.rsp_valid) begin
        chk("ready_low_in_resp", bus.req_ready, 0);
        if (clk_en) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
          end else begin
            c_rd = exp_q.pop_front();
            c_e  = exp_err_q.pop_front();
            c_en = exp_en_q.pop_front();
            chk("rsp_rdata", bus.rsp_rdata, c_rd);
            chk("rsp_err", bus.rsp_err, c_e);
            chk("rsp_latency_en_edges", en_cnt, c_en);
            last_rsp_cyc = cyc;
          end
        end
      end else begin
        chk("idle_rdata_zero", bus.rsp_rdata, 0);
        chk("idle_err_zero", bus.rsp_err, 0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before 400us");
    $fatal(1, "watchdog");
  end

  // stimulus
  logic [31:0] rd, rd0, a;
  logic        e, we;
  logic [2:0]  f3;
  int          n, r;

  initial begin
    rst = 1'b1;
    clk_en = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr = 32'd0;
    bus.req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", bus.req_ready, 1);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rdata", bus.rsp_rdata, 0);
    chk("reset_err", bus.rsp_err, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < DEPTH; i++) issue(1'b1, 3'b010, BASE + 32'(4*i), $urandom, rd, e);

    issue(1'b1, 3'b010, BASE + 32'h10, 32'hDEADBEEF, rd, e); chk("sw_ok", e, 0);
    issue(1'b0, 3'b010, BASE + 32'h10, 0, rd, e); chk("lw_deadbeef", rd, 32'hDEADBEEF);
    issue(1'b0, 3'b000, BASE + 32'h13, 0, rd, e); chk("lb_13", rd, 32'hFFFFFFDE);
    issue(1'b0, 3'b100, BASE + 32'h13, 0, rd, e); chk("lbu_13", rd, 32'h000000DE);
    issue(1'b0, 3'b001, BASE + 32'h12, 0, rd, e); chk("lh_12", rd, 32'hFFFFDEAD);
    issue(1'b0, 3'b101, BASE + 32'h10, 0, rd, e); chk("lhu_10", rd, 32'h0000BEEF);
    issue(1'b1, 3'b000, BASE + 32'h11, 32'h55, rd, e);
    issue(1'b0, 3'b010, BASE + 32'h10, 0, rd, e); chk("lw_after_sb", rd, 32'hDEAD55EF);

    issue(1'b0, 3'b010, BASE + 32'h12, 0, rd, e); chk("lw_misaligned_err", e, 1);
    chk("lw_misaligned_rdata", rd, 0);
    issue(1'b0, 3'b001, BASE + 32'h11, 0, rd, e); chk("lh_misaligned_err", e, 1);
    issue(1'b0, 3'b010, BASE, 0, rd0, e);
    issue(1'b1, 3'b010, BASE + SPAN, 32'h12345678, rd, e); chk("sw_oor_err", e, 1);
    issue(1'b0, 3'b010, BASE, 0, rd, e); chk("word0_unchanged", rd, rd0);
    issue(1'b0, 3'b011, BASE + 32'h10, 0, rd, e); chk("funct3_011_err", e, 1);
    issue(1'b0, 3'b010, BASE - 4, 0, rd, e); chk("below_base_err", e, 1);
    drain();

    // wait-state timing
    issue(1'b0, 3'b010, BASE + 32'h20, 0, rd, e);
    n = 0;
    while (!bus.req_ready && n < 20) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("ready_low_cycles", n, WS + 1);
    drain();
    chk("rsp_cycle_latency", last_rsp_cyc - acc_cyc, WS);

    // clk_en low for 4 cycles during WAIT
    issue(1'b0, 3'b010, BASE + 32'h10, 0, rd, e);
    clk_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    clk_en = 1'b1;
    drain();
    chk("stall_latency", last_rsp_cyc - acc_cyc, WS + 4);
    chk("stall_data", rd, 32'hDEAD55EF);

    // asynchronous reset mid-WAIT
    issue(1'b0, 3'b010, BASE + 32'h10, 0, rd, e);
    @(posedge clk);
    #2;
    flush = 1'b1;
    rst = 1'b1;
    #1;
    chk("midwait_rst_ready", bus.req_ready, 1);
    chk("midwait_rst_valid", bus.rsp_valid, 0);
    exp_q.delete();
    exp_err_q.delete();
    exp_en_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    flush = 1'b0;
    issue(1'b0, 3'b010, BASE + 32'h10, 0, rd, e);
    drain();

    // randomized traffic with random clk_en gaps
    rand_en = 1'b1;
    repeat (300) begin
      we = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else begin
        r = $urandom_range(0, 4);
        f3 = (r == 0) ? 3'b000 : (r == 1) ? 3'b001 : (r == 2) ? 3'b010 :
             (r == 3) ? 3'b100 : 3'b101;
        if (we) f3[2] = 1'b0;
      end
      r = $urandom_range(0, 9);
      if (r == 0)      a = BASE + SPAN + 32'($urandom_range(0, 15));
      else if (r == 1) a = BASE - 1 - 32'($urandom_range(0, 15));
      else begin
        a = BASE + 32'($urandom_range(0, SPAN - 1));
        if (r < 7) a = (f3[1:0] == 2'b00) ? a : (f3[1:0] == 2'b01) ? {a[31:1], 1'b0}
                                                                   : {a[31:2], 2'b00};
      end
      issue(we, f3, a, $urandom, rd, e);
    end
    rand_en = 1'b0;
    @(posedge clk);
    #1;
    clk_en = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Parametrised data memory with a load/store front end for the riscv-small core. It serves the MEM stage with a valid/ready request channel and a single-cycle response pulse. It supports RV32I byte, halfword and word accesses with sign or zero extension and byte-lane stores. Alignment, range and encoding checks run on every request, and a configurable number of wait states models slower memory. It replaces the flat word-only data memory and keeps its clock-enable gating.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, 16 to 65536.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.
- WAIT_STATES, 0: extra cycles between accept and response; 0 to 15.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clk_en  in  1  clock enable; when low, all sequential state holds.
- req_valid  in  1  request present.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  access size, RISC-V encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (low byte/halfword used for B/H).
- req_ready  out  1  block can accept a request this cycle.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  out  1  access faulted; valid only with rsp_valid.

## Operation
- **Accept.** A request is accepted on a rising edge where req_valid && req_ready && clk_en.
- **FSM states: IDLE, WAIT, RESP.**
  - IDLE: req_ready=1. On accept, go to WAIT if WAIT_STATES>0, else to RESP.
  - WAIT: down-counter loaded with WAIT_STATES-1 on accept. Go to RESP when the counter is 0.
  - RESP: rsp_valid=1 for exactly one enabled cycle, then IDLE.
- **Error checks,** all evaluated at accept:
  - misaligned: H/HU with addr[0]≠0, or W with addr[1:0]≠0;
  - out of range: addr < BASE_ADDR or addr ≥ BASE_ADDR+DEPTH_WORDS*4;
  - illegal funct3: for loads, 011/110/111; for stores, anything other than 000/001/010.
  - Any error gives rsp_err=1 and rsp_rdata=0, and no memory write.
- **Word index** = (addr-BASE_ADDR)[2 +: log2(DEPTH_WORDS)].
- **Store.**
  - Byte enables: SB → 1 lane at addr[1:0]; SH → lanes {addr[1],0} and {addr[1],1}; SW → all 4.
  - Write data is replicated into the lanes, and only enabled lanes are written.
  - The write takes effect on the accept edge. rsp_rdata=0 for stores.
- **Load.**
  - The word is read synchronously on the accept edge into a holding register.
  - The lane is selected by addr[1:0] (captured at accept).
  - Extension: B/H sign-extend; BU/HU zero-extend; W passes through.
- **Ordering.** A load issued after a store to the same word returns the stored data, since the store has already committed.
- **Memory reset.** Memory contents are not reset; they are X until written.

## Timing
- **Reset values:** state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- **Latency:** a request accepted at edge N produces rsp_valid high in the cycle after edge N+WAIT_STATES.
  - Example: WAIT_STATES=0 gives a response one cycle after accept.
- **Throughput:** one request per WAIT_STATES+2 cycles. req_ready is low in WAIT and RESP.
- **Held request:** request inputs are sampled only at accept. A request held after acceptance is not re-accepted until req_ready returns.
- **clk_en low:** state, counter, rsp_valid, rsp_rdata and rsp_err all hold. A RESP cycle with clk_en low stretches rsp_valid until the next enabled edge. No write occurs.
- **Reset mid-operation:** asynchronous rst returns the block to IDLE immediately and drops rsp_valid. A pending response is lost. A store already committed at accept stays in memory.
- **rsp_rdata / rsp_err:** registered. Stable only while rsp_valid=1; driven to 0 in other cycles.

## Test plan
- **Reset:** rst pulse mid-WAIT (WAIT_STATES=3) → req_ready=1, rsp_valid=0 asynchronously; next request is served normally.
- **Word store/load:** SW 32'hDEADBEEF to 0x10, then LW 0x10 → rsp_rdata=32'hDEADBEEF, rsp_err=0, rsp_valid one cycle after accept (WAIT_STATES=0).
- **Sub-word loads:** after that store:
  - LB 0x13 → 32'hFFFFFFDE; LBU 0x13 → 32'h000000DE;
  - LH 0x12 → 32'hFFFFDEAD; LHU 0x10 → 32'h0000BEEF.
- **Lane store:** SB 8'h55 to 0x11 → LW 0x10 returns 32'hDEAD55EF; other lanes are unchanged.
- **Errors:**
  - LW 0x12 and LH 0x11 → rsp_err=1, rsp_rdata=0;
  - SW to BASE_ADDR+DEPTH_WORDS*4 → rsp_err=1, and a later LW of word 0 is unchanged;
  - load funct3=011 → rsp_err=1.
- **Wait states / clk_en:**
  - WAIT_STATES=2: LW accepted at edge N → rsp_valid high in the cycle after edge N+2; req_ready low for 3 cycles.
  - clk_en low for 4 cycles during WAIT → response delayed by exactly 4 cycles with data unchanged.
